// File: rtl/core2wb_pkg.sv
// Shared types and helpers for the core-to-Wishbone bridge.
package core2wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_e;

    // Bits needed to hold an outstanding count in 0..max_out.
    function automatic int unsigned cnt_width(input int unsigned max_out);
        return (max_out < 2) ? 1 : $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/core2wb_wdog.sv
// Response watchdog for core2wb; flags expiry after TIMEOUT_CYCLES idle BUSY cycles.
// Only instantiated when CORE2WB_TIMEOUT_EN is defined.
module core2wb_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active,
    input  logic kick,
    output logic expire_c
);

    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wd_q;

    assign expire_c = active & ~kick & (wd_q == WW'(TIMEOUT_CYCLES - 1));

    // Counts cycles spent waiting with no response; restarts on any response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q <= '0;
        end else if (!active || kick || expire_c) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WW'(1);
        end
    end

endmodule

// File: rtl/core2wb.sv
// Bridge from a req/gnt/rvalid CPU port to a pipelined Wishbone B4 master.
// Optional response watchdog enabled by defining CORE2WB_TIMEOUT_EN.
module core2wb
    import core2wb_pkg::*;
#(
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            core_req,
    input  logic            core_we,
    input  logic [DW/8-1:0] core_be,
    input  logic [AW-1:0]   core_addr,
    input  logic [DW-1:0]   core_wdata,
    output logic            core_gnt,
    output logic            core_rvalid,
    output logic [DW-1:0]   core_rdata,
    output logic            core_err,

    output logic            wb_cyc,
    output logic            wb_stb,
    output logic            wb_we,
    output logic [DW/8-1:0] wb_sel,
    output logic [AW-1:0]   wb_adr,
    output logic [DW-1:0]   wb_dat_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack,
    input  logic            wb_err,
    input  logic            wb_stall
);

    localparam int unsigned CW = cnt_width(MAX_OUTSTANDING);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max_out
        $error("core2wb: MAX_OUTSTANDING must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("core2wb: TIMEOUT_CYCLES must be at least 1");
    end

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            room;
    logic            issue;
    logic            resp;
    logic            expire_c;

    // Request path is a straight pass-through; only stb/gnt are gated.
    assign room     = count_q < CW'(MAX_OUTSTANDING);
    assign wb_stb   = rst_ni & core_req & room & (state_q != ABORT);
    assign core_gnt = wb_stb & ~wb_stall;
    assign wb_cyc   = (state_q != ABORT) & (wb_stb | (count_q != '0));
    assign wb_we    = core_we;
    assign wb_sel   = core_be;
    assign wb_adr   = core_addr;
    assign wb_dat_o = core_wdata;

    assign issue = core_gnt;
    assign resp  = (state_q != ABORT) & (count_q != '0) & (wb_ack | wb_err);

`ifdef CORE2WB_TIMEOUT_EN
    core2wb_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .active   (state_q == BUSY),
        .kick     (resp),
        .expire_c (expire_c)
    );
`else
    assign expire_c = 1'b0;
`endif

    // Next state, outstanding count and registered response.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (issue) begin
                    count_d = count_q + CW'(1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (issue && !resp) begin
                    count_d = count_q + CW'(1);
                end else if (!issue && resp) begin
                    count_d = count_q - CW'(1);
                end
                if (expire_c) begin
                    state_d = ABORT;
                end else if (count_d == '0) begin
                    state_d = IDLE;
                end
            end
            ABORT: begin
                // Drain one synthetic error response per lost transfer.
                if (count_q != '0) begin
                    count_d  = count_q - CW'(1);
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                end
                if (count_q <= CW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        if (resp) begin
            rvalid_d = 1'b1;
            rdata_d  = wb_dat_i;
            err_d    = wb_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign core_rvalid = rvalid_q;
    assign core_rdata  = rdata_q;
    assign core_err    = err_q;

endmodule

// File: tb/tb_core2wb.sv
// Scoreboard bench for core2wb: directed stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever core_rvalid is seen.
module tb_core2wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we, core_gnt, core_rvalid, core_err;
    logic [3:0]  core_be;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err, wb_stall;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    core2wb #(
        .AW              (32),
        .DW              (32),
        .MAX_OUTSTANDING (2),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_be     (core_be),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .core_err    (core_err),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_sel      (wb_sel),
        .wb_adr      (wb_adr),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack      (wb_ack),
        .wb_err      (wb_err),
        .wb_stall    (wb_stall)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input logic [31:0] d, input logic e, input logic c);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.chk  = c;
        sb.push_back(x);
    endtask

    task automatic idle_in();
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_be    = 4'hF;
        core_addr  = 32'h0;
        core_wdata = 32'h0;
        wb_ack     = 1'b0;
        wb_err     = 1'b0;
        wb_stall   = 1'b0;
        wb_dat_i   = 32'h0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && core_rvalid) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", 64'(core_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("rsp_err", 64'(core_err), 64'(e.err));
                if (e.chk) check("rsp_data", 64'(core_rdata), 64'(e.data));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got hung expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] gnt_tab, req_tab, ack_tab;
        logic [8:0] cyc_tab;
        int         ng, ai, pi;

        // Reset: outputs quiet even with a pending request.
        rst_n = 1'b0;
        idle_in();
        core_req = 1'b1;
        #12;
        check("rst_stb", 64'(wb_stb), 64'd0);
        check("rst_gnt", 64'(core_gnt), 64'd0);
        check("rst_cyc", 64'(wb_cyc), 64'd0);
        check("rst_rvalid", 64'(core_rvalid), 64'd0);
        check("rst_err", 64'(core_err), 64'd0);
        check("rst_rdata", 64'(core_rdata), 64'd0);
        core_req = 1'b0;
        next();
        rst_n = 1'b1;
        next();

        // Single read to 0x100, ack next cycle.
        core_req  = 1'b1;
        core_addr = 32'h100;
        push(32'hDEADBEEF, 1'b0, 1'b1);
        sample();
        check("rd_gnt", 64'(core_gnt), 64'd1);
        check("rd_adr", 64'(wb_adr), 64'h100);
        check("rd_we", 64'(wb_we), 64'd0);
        check("rd_cyc", 64'(wb_cyc), 64'd1);
        next();
        core_req = 1'b0;
        wb_ack   = 1'b1;
        wb_dat_i = 32'hDEADBEEF;
        sample();
        check("rd_gnt_off", 64'(core_gnt), 64'd0);
        check("rd_cyc_wait", 64'(wb_cyc), 64'd1);
        check("rd_rvalid_early", 64'(core_rvalid), 64'd0);
        next();
        wb_ack   = 1'b0;
        wb_dat_i = 32'h0;
        sample();
        check("rd_rvalid", 64'(core_rvalid), 64'd1);
        check("rd_cyc_done", 64'(wb_cyc), 64'd0);
        next();
        sample();
        check("rd_rvalid_pulse", 64'(core_rvalid), 64'd0);
        check("rd_rdata_hold", 64'(core_rdata), 64'hDEADBEEF);
        next();

        // Held request, acks 3 cycles late, two outstanding max.
        req_tab = 8'b0001_1111;
        gnt_tab = 8'b0001_0011;
        ack_tab = 8'b1001_1000;
        cyc_tab = 9'b0_1111_1111;
        ng = 0;
        ai = 0;
        pi = 0;
        for (int i = 0; i < 9; i++) begin
            core_req  = (i < 8) ? req_tab[i] : 1'b0;
            core_addr = 32'(32'h400 + 4 * i);
            wb_ack    = (i < 8) ? ack_tab[i] : 1'b0;
            wb_dat_i  = 32'h0;
            if (wb_ack) begin
                wb_dat_i = 32'(32'h1111_1111 * (ai + 1));
                ai++;
            end
            if (i < 8 && gnt_tab[i]) begin
                push(32'(32'h1111_1111 * (pi + 1)), 1'b0, 1'b1);
                pi++;
            end
            sample();
            check("pipe_gnt", 64'(core_gnt), (i < 8) ? 64'(gnt_tab[i]) : 64'd0);
            check("pipe_stb", 64'(wb_stb), (i < 8) ? 64'(gnt_tab[i]) : 64'd0);
            check("pipe_cyc", 64'(wb_cyc), 64'(cyc_tab[i]));
            ng += int'(core_gnt);
            if (i == 3) check("pipe_ngnt", 64'(ng), 64'd2);
            next();
        end
        idle_in();

        // Stall for four cycles on a write, then slave errors it.
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = 32'h200;
        core_wdata = 32'hCAFEF00D;
        core_be    = 4'h3;
        wb_stall   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("stall_gnt", 64'(core_gnt), 64'd0);
            check("stall_stb", 64'(wb_stb), 64'd1);
            check("stall_adr", 64'(wb_adr), 64'h200);
            check("stall_dat", 64'(wb_dat_o), 64'hCAFEF00D);
            check("stall_sel", 64'(wb_sel), 64'h3);
            check("stall_we", 64'(wb_we), 64'd1);
            next();
        end
        wb_stall = 1'b0;
        push(32'h0BAD0BAD, 1'b1, 1'b1);
        sample();
        check("stall_release_gnt", 64'(core_gnt), 64'd1);
        next();
        core_req = 1'b0;
        wb_err   = 1'b1;
        wb_dat_i = 32'h0BAD0BAD;
        next();
        wb_err   = 1'b0;
        wb_dat_i = 32'h0;
        sample();
        check("werr_rvalid", 64'(core_rvalid), 64'd1);
        check("werr_err", 64'(core_err), 64'd1);
        next();
        idle_in();

        // Spurious ack/err with nothing outstanding.
        wb_dat_i = 32'h5555_5555;
        for (int i = 0; i < 4; i++) begin
            wb_ack = (i == 0);
            wb_err = (i == 1);
            sample();
            check("spur_cyc", 64'(wb_cyc), 64'd0);
            check("spur_rvalid", 64'(core_rvalid), 64'd0);
            next();
        end
        check("spur_rdata_hold", 64'(core_rdata), 64'h0BAD0BAD);
        idle_in();

`ifdef CORE2WB_TIMEOUT_EN
        // Two issued, never acked: abort drains two error responses.
        for (int i = 0; i < 13; i++) begin
            core_req  = (i < 2);
            core_addr = 32'(32'h800 + 4 * i);
            if (i < 2) push(32'h0, 1'b1, 1'b0);
            sample();
            check("to_cyc", 64'(wb_cyc), (i <= 8) ? 64'd1 : 64'd0);
            check("to_rvalid", 64'(core_rvalid), (i == 10 || i == 11) ? 64'd1 : 64'd0);
            next();
        end
        core_req  = 1'b1;
        core_addr = 32'h900;
        push(32'h0000600D, 1'b0, 1'b1);
        sample();
        check("to_regrant", 64'(core_gnt), 64'd1);
        next();
        core_req = 1'b0;
        wb_ack   = 1'b1;
        wb_dat_i = 32'h0000600D;
        next();
        idle_in();
        sample();
        check("to_after_rvalid", 64'(core_rvalid), 64'd1);
        next();
`else
        // Without watchdog a silent slave leaves the bridge waiting.
        core_req  = 1'b1;
        core_addr = 32'h800;
        push(32'h0000_0077, 1'b0, 1'b1);
        next();
        core_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample();
            check("wait_cyc", 64'(wb_cyc), 64'd1);
            check("wait_rvalid", 64'(core_rvalid), 64'd0);
            next();
        end
        wb_ack   = 1'b1;
        wb_dat_i = 32'h0000_0077;
        next();
        idle_in();
        sample();
        check("wait_rvalid_late", 64'(core_rvalid), 64'd1);
        next();
`endif

        // Reset with two outstanding: everything drops, responses discarded.
        core_req  = 1'b1;
        core_addr = 32'hA00;
        next();
        next();
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_cyc", 64'(wb_cyc), 64'd0);
        check("mrst_stb", 64'(wb_stb), 64'd0);
        check("mrst_gnt", 64'(core_gnt), 64'd0);
        check("mrst_rvalid", 64'(core_rvalid), 64'd0);
        check("mrst_err", 64'(core_err), 64'd0);
        check("mrst_rdata", 64'(core_rdata), 64'd0);
        next();
        idle_in();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_ack   = (i < 2);
            wb_dat_i = 32'h1234_5678;
            sample();
            check("post_rst_cyc", 64'(wb_cyc), 64'd0);
            check("post_rst_rvalid", 64'(core_rvalid), 64'd0);
            next();
        end
        idle_in();
        next();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/core2wb.md
CORE2WB -- requirements
Module: core2wb

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width; byte-enable width DW/8.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, maximum issued-but-unacknowledged Wishbone transfers (legal range 1..15).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit; used only with CORE2WB_TIMEOUT_EN.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have core-side inputs core_req (1), core_we (1), core_be (DW/8), core_addr (AW), core_wdata (DW), which carry the request from the CPU port.
REQ-008 SHALL have core-side outputs core_gnt (1), core_rvalid (1), core_rdata (DW), core_err (1).
REQ-009 SHALL have Wishbone master outputs wb_cyc (1), wb_stb (1), wb_we (1), wb_sel (DW/8), wb_adr (AW), wb_dat_o (DW).
REQ-010 SHALL have Wishbone master inputs wb_dat_i (DW), wb_ack (1), wb_err (1), wb_stall (1), pipelined Wishbone B4.

Function
REQ-011 SHALL drive wb_stb = core_req & room & (state != ABORT); room = outstanding count < MAX_OUTSTANDING.
REQ-012 SHALL drive wb_we/wb_sel/wb_adr/wb_dat_o combinationally from the core_* request fields.
REQ-013 SHALL drive core_gnt = wb_stb & ~wb_stall; a transfer is issued exactly on cycles where core_gnt is 1.
REQ-014 SHALL drive wb_cyc = wb_stb | (count != 0) in IDLE/BUSY, and 0 in ABORT.
REQ-015 SHALL hold an outstanding counter: +1 on issue, -1 on wb_ack|wb_err while count>0; simultaneous issue and response leave count unchanged.
REQ-016 SHALL ignore wb_ack/wb_err while count==0 (no underflow, no core_rvalid).
REQ-017 SHALL register responses: one cycle after a counted wb_ack|wb_err, assert core_rvalid for one cycle, with core_rdata = captured wb_dat_i and core_err = captured wb_err.
REQ-018 SHALL hold core_rdata stable between responses.
REQ-019 SHALL implement FSM IDLE (count==0), BUSY (count>0), ABORT; IDLE->BUSY on issue; BUSY->IDLE when count reaches 0; BUSY->ABORT on watchdog expiry.
REQ-020 SHALL, in ABORT, return one core_rvalid with core_err=1 per remaining outstanding transfer, one per cycle, then go to IDLE with count 0.
REQ-021 SHALL allow back-to-back issue every cycle when wb_stall=0 and room permits.

Reset
REQ-022 SHALL, while rst_ni=0, force state IDLE, count 0, watchdog 0, core_rvalid 0, core_err 0, core_rdata 0; wb_cyc/wb_stb/core_gnt therefore 0.
REQ-023 SHALL discard in-flight transfers on reset mid-operation; no responses for them after release.

Configuration
REQ-024 SHALL compile the watchdog only when macro CORE2WB_TIMEOUT_EN is defined: the counter clears on any counted response or when count==0, increments otherwise; reaching TIMEOUT_CYCLES enters ABORT.
REQ-025 SHALL, without CORE2WB_TIMEOUT_EN, contain no watchdog logic; ABORT is unreachable and BUSY waits indefinitely.

Structure
REQ-026 SHALL place the FSM state enum (IDLE, BUSY, ABORT) and the counter-width function in package core2wb_pkg.
REQ-027 SHALL implement the watchdog as sub-module core2wb_wdog, instantiated only under CORE2WB_TIMEOUT_EN.

Verification
REQ-028 Single read to 0x100, wb_ack next cycle with wb_dat_i=0xDEADBEEF -> core_gnt 1 cycle; core_rvalid 1 cycle after ack; core_rdata=0xDEADBEEF; core_err=0.
REQ-029 core_req held, wb_stall=0, acks delayed 3 cycles, MAX_OUTSTANDING=2 -> exactly 2 grants, then core_gnt=0 until first ack; no stb while full.
REQ-030 wb_stall=1 for 4 cycles -> core_gnt=0 and request fields stable; grant on first stall-free cycle.
REQ-031 Issue and ack in same cycle at count=1 -> count stays 1; wb_err on a write -> core_rvalid with core_err=1; spurious ack at count=0 -> no core_rvalid.
REQ-032 CORE2WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, two issued and no ack -> ABORT after 8 cycles; wb_cyc=0; two error responses on consecutive cycles; then IDLE.
REQ-033 rst_ni asserted with count=2 -> all outputs 0 immediately; no core_rvalid after release.
